// File: rtl/bit_logic_unit.sv
// Bitwise logic unit (AND/OR/XOR/NOR) with an optional multi-beat accumulate mode.
// A single output register provides pass-through valid/ready backpressure.
module bit_logic_unit #(
  parameter int WIDTH  = 32,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       op,
  input  logic             acc_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_zero_q, out_zero_d;

  logic             fire;
  logic             acc_beat;
  logic [WIDTH-1:0] first_res;
  logic [WIDTH-1:0] fold_res;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  // Ready depends only on the output register and out_ready, never on in_valid.
  assign in_ready  = !out_valid_q || out_ready;
  assign fire      = in_valid && in_ready;
  assign acc_beat  = ACC_EN && acc_mode;
  assign first_res = apply_op(op, in_a, in_b);
  assign fold_res  = apply_op(op_q, acc_q, in_a);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (fire) begin
      if (!acc_beat) begin
        // Plain beat; also aborts any sequence in progress.
        out_valid_d = 1'b1;
        out_data_d  = first_res;
        acc_d       = '0;
        state_d     = IDLE;
      end else if (state_q == IDLE) begin
        if (in_last) begin
          out_valid_d = 1'b1;
          out_data_d  = first_res;
        end else begin
          acc_d   = first_res;
          op_d    = op;
          state_d = ACC;
        end
      end else begin
        // In ACC only in_a is folded, using the op captured at sequence start.
        if (in_last) begin
          out_valid_d = 1'b1;
          out_data_d  = fold_res;
          acc_d       = '0;
          state_d     = IDLE;
        end else begin
          acc_d = fold_res;
        end
      end
    end

    out_zero_d = (out_data_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_bit_logic_unit.sv
// Scoreboard bench: 32-bit and 8-bit instances share one stimulus stream; a
// sequence-level reference model queues expected results for per-instance monitors.
module tb_bit_logic_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_a, in_b;
  logic [1:0]  op;
  logic        acc_mode, in_last, out_ready;

  logic        rdy32, ov32, oz32;
  logic [31:0] od32;
  logic        rdy8, ov8, oz8;
  logic [7:0]  od8;

  always #5 clock = ~clock;

  bit_logic_unit #(.WIDTH(32), .ACC_EN(1'b1)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_a(in_a), .in_b(in_b), .op(op), .acc_mode(acc_mode), .in_last(in_last),
    .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .out_zero(oz32)
  );

  bit_logic_unit #(.WIDTH(8), .ACC_EN(1'b1)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .op(op), .acc_mode(acc_mode), .in_last(in_last),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_zero(oz8)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q32[$];
  logic [7:0]  q8[$];
  bit          holding;
  bit          seq_active;
  logic [1:0]  seq_op;
  logic [31:0] seq_first;
  logic [31:0] seq_rest[$];

  function automatic logic [31:0] f(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] v);
    q32.push_back(v);
    q8.push_back(v[7:0]);
  endtask

  // A sequence is remembered as its first result plus the list of later in_a
  // values; the fold is evaluated only when the last beat arrives.
  task automatic model_fire(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                            input logic am, input logic last, output bit pushed);
    logic [31:0] r;
    pushed = 1'b0;
    if (!am) begin
      push_exp(f(o, a, b));
      pushed = 1'b1;
      seq_active = 1'b0;
      seq_rest.delete();
    end else if (!seq_active) begin
      if (last) begin
        push_exp(f(o, a, b));
        pushed = 1'b1;
      end else begin
        seq_active = 1'b1;
        seq_op     = o;
        seq_first  = f(o, a, b);
        seq_rest.delete();
      end
    end else if (!last) begin
      seq_rest.push_back(a);
    end else begin
      r = seq_first;
      foreach (seq_rest[i]) r = f(seq_op, r, seq_rest[i]);
      r = f(seq_op, r, a);
      push_exp(r);
      pushed = 1'b1;
      seq_active = 1'b0;
      seq_rest.delete();
    end
  endtask

  // One clock cycle of stimulus; returns at the negedge of that cycle.
  task automatic beat(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] o, input logic am, input logic last, input logic ordy);
    bit exp_ready;
    bit pushed;
    @(posedge clock);
    #1;
    in_valid = v; in_a = a; in_b = b; op = o;
    acc_mode = am; in_last = last; out_ready = ordy;
    @(negedge clock);
    exp_ready = !holding || ordy;
    check("in_ready32", {63'd0, rdy32}, {63'd0, exp_ready});
    check("in_ready8", {63'd0, rdy8}, {63'd0, exp_ready});
    check("out_valid32", {63'd0, ov32}, {63'd0, holding});
    pushed = 1'b0;
    if (v && exp_ready) model_fire(a, b, o, am, last, pushed);
    holding = pushed || (holding && !ordy);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    in_valid = 1'b0;
    #2;
    check("rst_out_valid", {63'd0, ov32}, 64'd0);
    check("rst_out_data", {32'd0, od32}, 64'd0);
    check("rst_out_zero", {63'd0, oz32}, 64'd1);
    check("rst_in_ready", {63'd0, rdy32}, 64'd1);
    check("rst_out_data8", {56'd0, od8}, 64'd0);
    q32.delete(); q8.delete(); seq_rest.delete();
    holding = 1'b0; seq_active = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_out_valid", {63'd0, ov32}, 64'd0);
    check("post_rst_in_ready", {63'd0, rdy32}, 64'd1);
  endtask

  // ---------------- monitors ----------------
  bit          hold32, hold8;
  logic [31:0] prev32;
  logic [7:0]  prev8;

  always @(negedge clock) begin
    logic [31:0] e;
    if (!reset_n) begin
      hold32 = 1'b0;
    end else begin
      if (ov32) begin
        if (hold32) check("stable32", {32'd0, od32}, {32'd0, prev32});
        if (out_ready) begin
          if (q32.size() == 0) begin
            check("unexpected_out32", {63'd0, ov32}, 64'd0);
          end else begin
            e = q32.pop_front();
            check("data32", {32'd0, od32}, {32'd0, e});
            check("zero32", {63'd0, oz32}, {63'd0, (e == 32'd0)});
          end
        end
      end
      hold32 = ov32 && !out_ready;
      prev32 = od32;
    end
  end

  always @(negedge clock) begin
    logic [7:0] e;
    if (!reset_n) begin
      hold8 = 1'b0;
    end else begin
      if (ov8) begin
        if (hold8) check("stable8", {56'd0, od8}, {56'd0, prev8});
        if (out_ready) begin
          if (q8.size() == 0) begin
            check("unexpected_out8", {63'd0, ov8}, 64'd0);
          end else begin
            e = q8.pop_front();
            check("data8", {56'd0, od8}, {56'd0, e});
            check("zero8", {63'd0, oz8}, {63'd0, (e == 8'd0)});
          end
        end
      end
      hold8 = ov8 && !out_ready;
      prev8 = od8;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] exp36[4];

  initial begin
    reset_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; op = 2'd0;
    acc_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    holding = 1'b0; seq_active = 1'b0;
    do_reset();

    // Pass-mode OR vector
    beat(1, 32'hF0F0_0000, 32'h0F0F_00FF, 2'd1, 0, 0, 1);
    beat(0, 0, 0, 2'd0, 0, 0, 1);
    check("pass_or", {32'd0, od32}, {32'd0, 32'hFFFF_00FF});
    check("pass_or_zero", {63'd0, oz32}, 64'd0);
    $display("txn pass OR -> %08h", od32);

    // All four ops back to back
    exp36[0] = 32'hAAAA_0000; exp36[1] = 32'hFFFF_AAAA;
    exp36[2] = 32'h5555_AAAA; exp36[3] = 32'h0000_5555;
    beat(1, 32'hAAAA_AAAA, 32'hFFFF_0000, 2'd0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      beat(i < 4, 32'hAAAA_AAAA, 32'hFFFF_0000, 2'(i), 0, 0, 1);
      check("all_ops", {32'd0, od32}, {32'd0, exp36[i-1]});
      $display("txn op=%0d -> %08h", i - 1, od32);
    end

    // Accumulate XOR; a NOR on the op input mid-sequence must be ignored
    beat(1, 32'd1, 32'd2, 2'd2, 1, 0, 1);
    beat(1, 32'd4, 32'hFFFF_FFFF, 2'd3, 1, 0, 1);
    beat(1, 32'd8, 32'd0, 2'd0, 1, 1, 1);
    beat(0, 0, 0, 2'd0, 0, 0, 1);
    check("acc_xor", {32'd0, od32}, 64'h0000_000F);
    $display("txn acc xor -> %08h", od32);

    // Backpressure: held result, in_ready low, then released in the same cycle
    beat(1, 32'h1234_5678, 32'h0000_FFFF, 2'd0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      beat(1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'd1, 0, 0, 0);
      check("bp_hold_data", {32'd0, od32}, 64'h0000_5678);
      check("bp_in_ready", {63'd0, rdy32}, 64'd0);
    end
    beat(1, 32'h0F00_0000, 32'h00F0_0000, 2'd1, 0, 0, 1);
    check("bp_release_ready", {63'd0, rdy32}, 64'd1);
    beat(0, 0, 0, 2'd0, 0, 0, 1);
    check("bp_new_data", {32'd0, od32}, 64'h0FF0_0000);
    $display("txn backpressure release -> %08h", od32);

    // Reset mid-sequence discards the partial accumulation
    beat(1, 32'h0000_00F0, 32'h0000_000F, 2'd1, 1, 0, 1);
    beat(1, 32'h0000_0F00, 32'd0, 2'd1, 1, 0, 1);
    do_reset();
    beat(1, 32'd0, 32'd0, 2'd0, 0, 0, 1);
    beat(0, 0, 0, 2'd0, 0, 0, 1);
    check("after_rst_and", {32'd0, od32}, 64'd0);
    check("after_rst_zero", {63'd0, oz32}, 64'd1);
    $display("txn post-reset AND -> %08h zero=%0b", od32, oz32);

    // 8-bit NOR vector
    beat(1, 32'h0000_000F, 32'h0000_0030, 2'd3, 0, 0, 1);
    beat(0, 0, 0, 2'd0, 0, 0, 1);
    check("w8_nor", {56'd0, od8}, 64'hC0);
    $display("txn w8 NOR -> %02h", od8);

    // Random traffic across ops, modes and backpressure
    for (int n = 0; n < 10000; n++) begin
      beat($urandom_range(0, 9) < 8, $urandom, $urandom, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
    end
    for (int n = 0; n < 4; n++) beat(0, 0, 0, 2'd0, 0, 0, 1);
    check("drain32", 64'(q32.size()), 64'd0);
    check("drain8", 64'(q8.size()), 64'd0);
    $display("txn random 10000 beats done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_logic_unit.md
BIT_LOGIC_UNIT -- requirements
Module: bit_logic_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits (legal range 1..64).
REQ-002 Parameter: ACC_EN, default 1, when 0 accumulate mode is not built and acc_mode is ignored (treated as 0).
REQ-003 Port: clock  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  operand beat presented.
REQ-006 Port: in_ready  output  1  unit accepts beat this cycle.
REQ-007 Port: in_a  input  WIDTH  operand A.
REQ-008 Port: in_b  input  WIDTH  operand B.
REQ-009 Port: op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 Port: acc_mode  input  1  1 = fold beats into running accumulator.
REQ-011 Port: in_last  input  1  final beat of an accumulate sequence, ignored when acc_mode=0.
REQ-012 Port: out_valid  output  1  result held on out_data.
REQ-013 Port: out_ready  input  1  downstream takes result.
REQ-014 Port: out_data  output  WIDTH  result.
REQ-015 Port: out_zero  output  1  out_data is all zeros, valid with out_valid.

Function
REQ-016 Beat accepted ("fire") when in_valid && in_ready; result transferred when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (single output register, pass-through backpressure, combinational on out_ready only).
REQ-018 Pass mode (acc_mode=0): fire in cycle N -> out_data = in_a OP in_b, out_valid=1 in cycle N+1 (latency 1); back-to-back fires with out_ready=1 give one result per cycle.
REQ-019 Op sampled per beat; a change of op between beats takes effect on the next fired beat only.
REQ-020 Accumulate state machine states: IDLE, ACC.
REQ-021 IDLE, fire with acc_mode=1, in_last=0 -> acc <= in_a OP in_b, go ACC, no output.
REQ-022 ACC, fire with acc_mode=1, in_last=0 -> acc <= acc OP in_a, stay ACC, no output; in_b ignored in ACC.
REQ-023 ACC, fire with acc_mode=1, in_last=1 -> out_data <= acc OP in_a, out_valid=1 next cycle, go IDLE.
REQ-024 IDLE, fire with acc_mode=1, in_last=1 -> single-beat sequence, out_data <= in_a OP in_b, stays IDLE.
REQ-025 ACC, fire with acc_mode=0 -> sequence aborted, acc discarded, beat processed per REQ-018, go IDLE.
REQ-026 Op used in ACC is the op latched at the first beat of the sequence; op input ignored until IDLE.
REQ-027 During ACC non-last beats in_ready SHALL still follow REQ-017 (beats accepted while a prior result awaits out_ready only if out_ready=1).
REQ-028 out_data and out_zero SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 out_zero = (out_data == 0), registered with out_data.
REQ-030 Bitwise only: no carries, bit i of result depends only on bit i of operands/acc.

Reset
REQ-031 reset_n low asynchronously forces out_valid=0, out_data=0, out_zero=1, acc=0, state IDLE, latched op=00.
REQ-032 Reset asserted mid-sequence SHALL discard the partial accumulation; no result emitted for it.
REQ-033 in_ready SHALL read 1 during and immediately after reset (out_valid=0).
REQ-034 Outputs leave reset values only on the first clock edge after reset_n rises.

Verification
REQ-035 Pass, WIDTH=32: a=0xF0F0_0000, b=0x0F0F_00FF, op=OR, out_ready=1 -> next cycle out_data=0xFFFF_00FF, out_zero=0.
REQ-036 All ops: a=0xAAAA_AAAA, b=0xFFFF_0000 -> AND 0xAAAA_0000, OR 0xFFFF_AAAA, XOR 0x5555_AAAA, NOR 0x0000_5555.
REQ-037 Accumulate XOR: beats (a=1,b=2),(a=4),(a=8,last) -> single result 0x0000_000F after last beat, no output before.
REQ-038 Backpressure: out_ready=0 for 3 cycles with result held -> in_ready=0, out_data stable; out_ready=1 -> in_ready=1 same cycle, new beat accepted.
REQ-039 Abort/reset: ACC with 2 beats folded, then reset_n pulse -> out_valid=0, out_data=0, out_zero=1; following pass beat a=0,b=0,AND -> out_data=0, out_zero=1.
REQ-040 WIDTH=8 instance: NOR of 0x0F,0x30 -> 0xC0; random-stimulus scoreboard vs reference model across ops and modes for 10k beats.
